// File: rtl/seq_alu_param_if.sv
// seq_alu_param_if: START/DONE operand and result bundle for the multi-cycle ALU.
interface seq_alu_param_if #(parameter int WIDTH = 40);
    logic             start;
    logic [1:0]       op;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             cout;
    logic             ovf;
    logic             divz;
    modport master (output start, op, sgn, a, b,
                    input  busy, done, result, result_hi, cout, ovf, divz);
    modport slave  (input  start, op, sgn, a, b,
                    output busy, done, result, result_hi, cout, ovf, divz);
endinterface

// File: rtl/seq_alu_param.sv
// seq_alu_param: multi-cycle add/sub/mul/div ALU, signed or unsigned, START/DONE handshake.
module seq_alu_param #(parameter int WIDTH = 40) (
    input logic           i_clk,
    input logic           i_rst,
    seq_alu_param_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, EXEC, ITER, FIX, FIN} state_t;
    state_t             r_state;
    logic [1:0]         r_op;
    logic               r_sgn, r_sa, r_sb, r_busy, r_done, r_cout, r_ovf, r_divz;
    logic [WIDTH-1:0]   r_a, r_b, r_ma, r_mb, r_res, r_hi;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               w_na, w_nb, w_dz, w_asovf, w_fovf;
    logic [WIDTH-1:0]   w_ma, w_mb, w_q, w_r, w_ph;
    logic [WIDTH:0]     w_as, w_sum, w_sh, w_diff;
    logic [2*WIDTH-1:0] w_step, w_prod;
    assign w_na = bus.sgn & bus.a[WIDTH-1];
    assign w_nb = bus.sgn & bus.b[WIDTH-1];
    assign w_ma = w_na ? -bus.a : bus.a;
    assign w_mb = w_nb ? -bus.b : bus.b;
    assign w_as = {1'b0, r_a} + {1'b0, r_op[0] ? ~r_b : r_b} + (WIDTH+1)'(r_op[0]);
    assign w_dz = &r_op;
    assign w_asovf = r_sgn ? (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ r_op[0])) && (w_as[WIDTH-1] != r_a[WIDTH-1])
                           : w_as[WIDTH] ^ r_op[0];
    // Multiply shifts the accumulator right; divide shifts the partial remainder left.
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_ma} : '0);
    assign w_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff = w_sh - {1'b0, r_mb};
    assign w_step = !r_op[0] ? {w_sum, r_acc[WIDTH-1:1]}
                  : w_diff[WIDTH] ? {w_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                  : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_ph   = w_prod[2*WIDTH-1:WIDTH];
    assign w_q    = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_r    = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    // A quotient magnitude reaching 2^(WIDTH-1) with positive sign only arises from MIN/-1.
    assign w_fovf = r_op[0] ? r_sgn & ~(r_sa ^ r_sb) & r_acc[WIDTH-1]
                  : r_sgn ? w_ph != {WIDTH{w_prod[WIDTH-1]}} : |w_ph;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_sgn   <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_divz  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_res   <= '0;
            r_hi    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_op    <= bus.op;
                    r_sgn   <= bus.sgn;
                    r_a     <= bus.a;
                    r_b     <= bus.b;
                    r_sa    <= w_na;
                    r_sb    <= w_nb;
                    r_ma    <= w_ma;
                    r_mb    <= w_mb;
                    r_acc   <= {{WIDTH{1'b0}}, bus.op[0] ? w_ma : w_mb};
                    r_cnt   <= CW'(WIDTH - 1);
                    r_busy  <= 1'b1;
                    r_state <= (!bus.op[1] || (bus.op[0] && bus.b == '0)) ? EXEC : ITER;
                end
                EXEC: begin
                    r_res   <= w_dz ? '1 : w_as[WIDTH-1:0];
                    r_hi    <= w_dz ? r_a : '0;
                    r_cout  <= !w_dz & w_as[WIDTH];
                    r_ovf   <= !w_dz & w_asovf;
                    r_divz  <= w_dz;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= FIN;
                end
                ITER: begin
                    r_acc   <= w_step;
                    r_cnt   <= r_cnt - CW'(1);
                    r_state <= r_cnt == '0 ? FIX : ITER;
                end
                FIX: begin
                    r_res   <= r_op[0] ? w_q : w_prod[WIDTH-1:0];
                    r_hi    <= r_op[0] ? w_r : w_ph;
                    r_cout  <= 1'b0;
                    r_ovf   <= w_fovf;
                    r_divz  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= FIN;
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_res;
    assign bus.result_hi = r_hi;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.divz      = r_divz;
endmodule

// File: tb/tb_seq_alu_param.sv
// tb_seq_alu_param: directed vector table at WIDTH=8 plus handshake, reset and WIDTH=40 sequences.
module tb_seq_alu_param;
    logic clk = 1'b0;
    logic rst8 = 1'b1;
    logic rst40 = 1'b1;
    always #5 clk = ~clk;
    seq_alu_param_if #(.WIDTH(8))  b8();
    seq_alu_param_if #(.WIDTH(40)) b40();
    seq_alu_param #(.WIDTH(8))  dut8  (.i_clk(clk), .i_rst(rst8),  .bus(b8));
    seq_alu_param #(.WIDTH(40)) dut40 (.i_clk(clk), .i_rst(rst40), .bus(b40));

    typedef struct {
        string      name;
        logic [1:0] op;
        logic       sgn;
        logic [7:0] a, b, res, hi;
        logic       cout, ovf, divz;
        int         lat;
    } vec_t;
    vec_t vt[$];
    int n_cmp = 0;
    int n_err = 0;
    int lat, ndone;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic go8(input logic [1:0] op, input logic sgn, input logic [7:0] a, input logic [7:0] b, output int l);
        b8.start = 1'b1; b8.op = op; b8.sgn = sgn; b8.a = a; b8.b = b;
        @(posedge clk); #1;
        b8.start = 1'b0; b8.op = 2'($urandom); b8.sgn = 1'($urandom);
        b8.a = 8'($urandom); b8.b = 8'($urandom);
        chk("busy8 after accept", 64'(b8.busy), 64'd1);
        l = 0;
        do begin @(posedge clk); #1; l++; end while (!b8.done && l < 100);
        if (!b8.done) l = -1;
    endtask

    task automatic go40(input logic [1:0] op, input logic sgn, input logic [39:0] a, input logic [39:0] b, output int l);
        b40.start = 1'b1; b40.op = op; b40.sgn = sgn; b40.a = a; b40.b = b;
        @(posedge clk); #1;
        b40.start = 1'b0; b40.a = 40'($urandom); b40.b = 40'($urandom);
        l = 0;
        do begin @(posedge clk); #1; l++; end while (!b40.done && l < 100);
        if (!b40.done) l = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        b8.start = 1'b1; b8.op = 2'b00; b8.sgn = 1'b0; b8.a = 8'd1; b8.b = 8'd1;
        b40.start = 1'b0; b40.op = 2'b00; b40.sgn = 1'b0; b40.a = '0; b40.b = '0;
        vt.push_back('{"add s 100+50",  2'b00, 1'b1, 8'd100, 8'd50,  8'h96, 8'h00, 1'b0, 1'b1, 1'b0, 1});
        vt.push_back('{"sub u 3-5",     2'b01, 1'b0, 8'd3,   8'd5,   8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1});
        vt.push_back('{"add u ff+1",    2'b00, 1'b0, 8'hFF,  8'h01,  8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1});
        vt.push_back('{"sub s 80-1",    2'b01, 1'b1, 8'h80,  8'h01,  8'h7F, 8'h00, 1'b1, 1'b1, 1'b0, 1});
        vt.push_back('{"sub u 5-3",     2'b01, 1'b0, 8'd5,   8'd3,   8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1});
        vt.push_back('{"add s -1+1",    2'b00, 1'b1, 8'hFF,  8'h01,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1});
        vt.push_back('{"mul u 200*3",   2'b10, 1'b0, 8'd200, 8'd3,   8'h58, 8'h02, 1'b0, 1'b1, 1'b0, 9});
        vt.push_back('{"mul s -3*5",    2'b10, 1'b1, 8'hFD,  8'h05,  8'hF1, 8'hFF, 1'b0, 1'b0, 1'b0, 9});
        vt.push_back('{"mul s -128*-1", 2'b10, 1'b1, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 9});
        vt.push_back('{"mul u ff*ff",   2'b10, 1'b0, 8'hFF,  8'hFF,  8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 9});
        vt.push_back('{"mul s -1*-1",   2'b10, 1'b1, 8'hFF,  8'hFF,  8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 9});
        vt.push_back('{"mul u 0*55",    2'b10, 1'b0, 8'h00,  8'h55,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 9});
        vt.push_back('{"div s -7/2",    2'b11, 1'b1, 8'hF9,  8'h02,  8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0, 9});
        vt.push_back('{"div s 7/-2",    2'b11, 1'b1, 8'h07,  8'hFE,  8'hFD, 8'h01, 1'b0, 1'b0, 1'b0, 9});
        vt.push_back('{"div u 250/7",   2'b11, 1'b0, 8'd250, 8'd7,   8'd35,  8'd5,  1'b0, 1'b0, 1'b0, 9});
        vt.push_back('{"div s 80/ff",   2'b11, 1'b1, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 9});
        vt.push_back('{"div u 80/ff",   2'b11, 1'b0, 8'h80,  8'hFF,  8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 9});
        vt.push_back('{"div u ff/1",    2'b11, 1'b0, 8'hFF,  8'h01,  8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 9});
        vt.push_back('{"divz u 2a/0",   2'b11, 1'b0, 8'h2A,  8'h00,  8'hFF, 8'h2A, 1'b0, 1'b0, 1'b1, 1});
        vt.push_back('{"divz s 85/0",   2'b11, 1'b1, 8'h85,  8'h00,  8'hFF, 8'h85, 1'b0, 1'b0, 1'b1, 1});

        // START held during reset must not launch anything.
        repeat (3) @(posedge clk);
        #1;
        chk("rst8 busy", 64'(b8.busy), 64'd0);
        chk("rst8 done", 64'(b8.done), 64'd0);
        chk("rst8 result", 64'(b8.result), 64'd0);
        chk("rst8 flags", 64'({b8.cout, b8.ovf, b8.divz}), 64'd0);
        b8.start = 1'b0;
        rst8 = 1'b0;
        rst40 = 1'b0;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            go8(vt[i].op, vt[i].sgn, vt[i].a, vt[i].b, lat);
            chk({vt[i].name, " lat"}, 64'(lat), 64'(vt[i].lat));
            chk({vt[i].name, " res"}, 64'(b8.result), 64'(vt[i].res));
            chk({vt[i].name, " hi"}, 64'(b8.result_hi), 64'(vt[i].hi));
            chk({vt[i].name, " cout/ovf/divz"}, 64'({b8.cout, b8.ovf, b8.divz}), 64'({vt[i].cout, vt[i].ovf, vt[i].divz}));
            chk({vt[i].name, " busy at done"}, 64'(b8.busy), 64'd0);
            @(posedge clk); #1;
            chk({vt[i].name, " done pulse"}, 64'(b8.done), 64'd0);
        end

        // START pulses during BUSY and held through FIN are ignored.
        b8.start = 1'b1; b8.op = 2'b10; b8.sgn = 1'b0; b8.a = 8'd200; b8.b = 8'd3;
        @(posedge clk); #1;
        b8.op = 2'b00; b8.a = 8'd1; b8.b = 8'd1;
        ndone = 0; lat = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (b8.done) begin
                ndone++;
                if (lat == 0) lat = k + 1;
            end
            if (lat != 0 && k == lat) b8.start = 1'b0;
        end
        b8.start = 1'b0;
        chk("ignore start done count", 64'(ndone), 64'd1);
        chk("ignore start lat", 64'(lat), 64'd9);
        chk("ignore start res", 64'({b8.result_hi, b8.result}), 64'h0258);

        // Back-to-back: START during FIN rejected, accepted on first IDLE cycle.
        go8(2'b00, 1'b0, 8'd1, 8'd2, lat);
        chk("b2b first res", 64'(b8.result), 64'd3);
        b8.start = 1'b1; b8.op = 2'b00; b8.sgn = 1'b0; b8.a = 8'd10; b8.b = 8'd20;
        @(posedge clk); #1;
        chk("b2b fin rejects busy", 64'(b8.busy), 64'd0);
        chk("b2b fin rejects done", 64'(b8.done), 64'd0);
        @(posedge clk); #1;
        b8.start = 1'b0;
        chk("b2b accepted busy", 64'(b8.busy), 64'd1);
        @(posedge clk); #1;
        chk("b2b done", 64'(b8.done), 64'd1);
        chk("b2b res", 64'(b8.result), 64'd30);
        @(posedge clk); #1;

        // WIDTH=40: signed and unsigned multiply, then reset mid-multiply.
        go40(2'b10, 1'b1, 40'hFF_FFFF_FFFE, 40'd3, lat);
        chk("w40 mul s lat", 64'(lat), 64'd41);
        chk("w40 mul s res", 64'(b40.result), 64'hFF_FFFF_FFFA);
        chk("w40 mul s hi", 64'(b40.result_hi), 64'hFF_FFFF_FFFF);
        chk("w40 mul s ovf", 64'(b40.ovf), 64'd0);
        @(posedge clk); #1;
        go40(2'b10, 1'b0, 40'hFF_FFFF_FFFF, 40'd2, lat);
        chk("w40 mul u lat", 64'(lat), 64'd41);
        chk("w40 mul u res", 64'(b40.result), 64'hFF_FFFF_FFFE);
        chk("w40 mul u hi", 64'(b40.result_hi), 64'h1);
        chk("w40 mul u ovf", 64'(b40.ovf), 64'd1);
        @(posedge clk); #1;
        b40.start = 1'b1; b40.op = 2'b10; b40.sgn = 1'b0; b40.a = 40'd12345; b40.b = 40'd678;
        @(posedge clk); #1;
        b40.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst40 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("w40 rst busy/done", 64'({b40.busy, b40.done}), 64'd0);
        chk("w40 rst res", 64'(b40.result), 64'd0);
        chk("w40 rst hi", 64'(b40.result_hi), 64'd0);
        chk("w40 rst flags", 64'({b40.cout, b40.ovf, b40.divz}), 64'd0);
        rst40 = 1'b0;
        go40(2'b00, 1'b0, 40'd5, 40'd7, lat);
        chk("w40 add after rst lat", 64'(lat), 64'd1);
        chk("w40 add after rst res", 64'(b40.result), 64'd12);
        @(posedge clk); #1;
        chk("w40 add done pulse", 64'(b40.done), 64'd0);
        repeat (45) @(posedge clk);
        #1;
        chk("w40 no stray done", 64'(b40.done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
